// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ core: pulses per-stage enables, owns the
// data-memory handshake and status code. Define SEQ_PERF_EN to enable the retire/cycle counters.
module seq_stage_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic        imem_err,
  input  logic        cond,
  input  logic        mem_ack,
  input  logic        dmem_err,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        wb_en,
  output logic        pc_en,
  output logic        mem_req,
  output logic [2:0]  stat,
  output logic        busy,
  output logic [31:0] instr_retired,
  output logic [31:0] cycle_count
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback, StPcupd, StHalted
  } state_e;

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [2:0] stat_q, stat_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] icode_q, ifun_q;
  logic       needs_mem, needs_wb, cmov_skip;
  logic       fetch_q, decode_q, exec_q, wb_q, pc_q, mem_q, busy_q;

  always_comb begin
    needs_mem = 1'b0;
    needs_wb  = 1'b0;
    case (icode_q)
      4'h4:                         needs_mem = 1'b1;
      4'h5, 4'h8, 4'h9, 4'hA, 4'hB: begin
        needs_mem = 1'b1;
        needs_wb  = 1'b1;
      end
      4'h2, 4'h3, 4'h6:             needs_wb  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StFetch;
      StFetch: begin
        // imem_err outranks an invalid icode
        if (imem_err) begin
          state_d = StHalted;
          stat_d  = StatAdr;
        end else if (icode > 4'hB) begin
          state_d = StHalted;
          stat_d  = StatIns;
        end else if (icode == 4'h0) begin
          state_d = StHalted;
          stat_d  = StatHlt;
        end else begin
          state_d = StDecode;
        end
      end
      StDecode:  state_d = StExecute;
      StExecute: begin
        wait_d = 8'd0;
        if (needs_mem)     state_d = StMemory;
        else if (needs_wb) state_d = StWriteback;
        else               state_d = StPcupd;
      end
      StMemory: begin
        // an ack in the timeout cycle still completes the access
        if (mem_ack) begin
          if (dmem_err) begin
            state_d = StHalted;
            stat_d  = StatAdr;
          end else if (needs_wb) begin
            state_d = StWriteback;
          end else begin
            state_d = StPcupd;
          end
        end else if (wait_q == WaitLast) begin
          state_d = StHalted;
          stat_d  = StatAdr;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWriteback: state_d = StPcupd;
      StPcupd:     state_d = StFetch;
      StHalted:    state_d = StHalted;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      stat_q   <= StatAok;
      wait_q   <= 8'd0;
      icode_q  <= 4'h0;
      ifun_q   <= 4'h0;
      fetch_q  <= 1'b0;
      decode_q <= 1'b0;
      exec_q   <= 1'b0;
      wb_q     <= 1'b0;
      pc_q     <= 1'b0;
      mem_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stat_q   <= stat_d;
      wait_q   <= wait_d;
      if (state_q == StFetch) begin
        icode_q <= icode;
        ifun_q  <= ifun;
      end
      fetch_q  <= (state_d == StFetch);
      decode_q <= (state_d == StDecode);
      exec_q   <= (state_d == StExecute);
      wb_q     <= (state_d == StWriteback);
      pc_q     <= (state_d == StPcupd);
      mem_q    <= (state_d == StMemory);
      busy_q   <= (state_d != StIdle) && (state_d != StHalted);
    end
  end

  // cond only becomes valid in WRITEBACK, so the untaken-cmov gate is applied late
  assign cmov_skip = (icode_q == 4'h2) && (ifun_q != 4'h0) && !cond;

  assign fetch_en  = fetch_q;
  assign decode_en = decode_q;
  assign exec_en   = exec_q;
  assign wb_en     = wb_q && !cmov_skip;
  assign pc_en     = pc_q;
  assign mem_req   = mem_q;
  assign stat      = stat_q;
  assign busy      = busy_q;

`ifdef SEQ_PERF_EN
  logic [31:0] retired_q, cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
      cycles_q  <= 32'd0;
    end else begin
      if (busy_q)             cycles_q  <= cycles_q + 32'd1;
      if (state_q == StPcupd) retired_q <= retired_q + 32'd1;
    end
  end

  assign instr_retired = retired_q;
  assign cycle_count   = cycles_q;
`else
  assign instr_retired = 32'd0;
  assign cycle_count   = 32'd0;
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl; expected values queue up with the stimulus and are
// popped against the DUT outputs after each clock.
module tb_seq_stage_ctrl;

  logic        clk, rst_n, start, imem_err, cond, mem_ack, dmem_err;
  logic [3:0]  icode, ifun;
  logic        fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req, busy;
  logic [2:0]  stat;
  logic [31:0] instr_retired, cycle_count;

  int vectors = 0;
  int miscompares = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];

`ifdef SEQ_PERF_EN
  localparam logic [31:0] PerfMask = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] PerfMask = 32'h0;
`endif

  localparam logic [31:0] F = 32'h20, D = 32'h10, E = 32'h08, W = 32'h04, P = 32'h02;
  localparam logic [31:0] M = 32'h01, Z = 32'h00;

  seq_stage_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .ifun(ifun),
    .imem_err(imem_err), .cond(cond), .mem_ack(mem_ack), .dmem_err(dmem_err),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
    .pc_en(pc_en), .mem_req(mem_req), .stat(stat), .busy(busy),
    .instr_retired(instr_retired), .cycle_count(cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] en_vec();
    return {26'd0, fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    vectors++;
    if (val_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
      return;
    end
    t = tag_q.pop_front();
    e = val_q.pop_front();
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // expect an enable pattern after the next clock
  task automatic cyc(input string tag, input logic [31:0] e);
    push(tag, e);
    step();
    pop_check(en_vec());
  endtask

  task automatic now(input string tag, input logic [31:0] e, input logic [31:0] obs);
    push(tag, e);
    pop_check(obs);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; icode = 4'h0; ifun = 4'h0; imem_err = 1'b0;
    cond = 1'b0; mem_ack = 1'b0; dmem_err = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state, then irmovq followed by halt
    do_reset();
    now("rst_en", Z, en_vec());
    now("rst_stat", 32'd1, 32'(stat));
    now("rst_busy", 32'd0, 32'(busy));
    now("rst_ret", 32'd0, instr_retired);
    now("rst_cyc", 32'd0, cycle_count);
    start = 1'b1; icode = 4'h3;
    cyc("t1_fetch", F);
    now("t1_busy", 32'd1, 32'(busy));
    cyc("t1_decode", D);
    cyc("t1_exec", E);
    cyc("t1_wb", W);
    cyc("t1_pc", P);
    icode = 4'h0;
    cyc("t1_fetch2", F);
    now("t1_ret_mid", 32'd1 & PerfMask, instr_retired);
    cyc("t1_halted", Z);
    now("t1_stat", 32'd2, 32'(stat));
    now("t1_busy_end", 32'd0, 32'(busy));
    now("t1_ret", 32'd1 & PerfMask, instr_retired);
    now("t1_cyc", 32'd6 & PerfMask, cycle_count);

    // mrmovq, ack on third MEMORY cycle; stray ack in DECODE is ignored
    do_reset();
    start = 1'b1; icode = 4'h5;
    cyc("t2_fetch", F);
    cyc("t2_decode", D);
    mem_ack = 1'b1;
    cyc("t2_exec", E);
    mem_ack = 1'b0;
    cyc("t2_mem1", M);
    cyc("t2_mem2", M);
    cyc("t2_mem3", M);
    mem_ack = 1'b1;
    cyc("t2_wb", W);
    mem_ack = 1'b0;
    cyc("t2_pc", P);
    cyc("t2_fetch2", F);
    now("t2_ret", 32'd1 & PerfMask, instr_retired);
    now("t2_cyc", 32'd8 & PerfMask, cycle_count);
    cyc("t2b_decode", D);
    cyc("t2b_exec", E);
    cyc("t2b_mem", M);
    mem_ack = 1'b1; dmem_err = 1'b1;
    cyc("t2b_halted", Z);
    mem_ack = 1'b0; dmem_err = 1'b0;
    now("t2b_stat", 32'd3, 32'(stat));

    // cmovle: untaken then taken in the same WRITEBACK, then unconditional rrmovq
    do_reset();
    start = 1'b1; icode = 4'h2; ifun = 4'h1;
    cyc("t3_fetch", F);
    cyc("t3_decode", D);
    cyc("t3_exec", E);
    cond = 1'b0;
    cyc("t3_wb_untaken", Z);
    now("t3_wb_busy", 32'd1, 32'(busy));
    cond = 1'b1;
    #1;
    now("t3_wb_taken", 32'd1, 32'(wb_en));
    cond = 1'b0;
    cyc("t3_pc", P);
    ifun = 4'h0;
    cyc("t3_fetch2", F);
    cyc("t3_decode2", D);
    cyc("t3_exec2", E);
    cyc("t3_wb_rrmov", W);
    cyc("t3_pc2", P);

    // invalid icode, then imem_err with invalid icode
    do_reset();
    start = 1'b1; icode = 4'hC;
    cyc("t4_fetch", F);
    cyc("t4_halted", Z);
    now("t4_stat", 32'd4, 32'(stat));
    cyc("t4_absorb", Z);
    do_reset();
    start = 1'b1; icode = 4'hD; imem_err = 1'b1;
    cyc("t4b_fetch", F);
    cyc("t4b_halted", Z);
    imem_err = 1'b0;
    now("t4b_stat", 32'd3, 32'(stat));

    // pushq with no ack: 15 MEMORY cycles then address fault
    do_reset();
    start = 1'b1; icode = 4'hA;
    cyc("t5_fetch", F);
    cyc("t5_decode", D);
    cyc("t5_exec", E);
    for (int i = 0; i < 15; i++) cyc("t5_mem_wait", M);
    cyc("t5_halted", Z);
    now("t5_stat", 32'd3, 32'(stat));

    // rmmovq with ack in the timeout cycle: ack wins
    do_reset();
    start = 1'b1; icode = 4'h4;
    cyc("t5b_fetch", F);
    cyc("t5b_decode", D);
    cyc("t5b_exec", E);
    for (int i = 0; i < 15; i++) cyc("t5b_mem_wait", M);
    mem_ack = 1'b1;
    cyc("t5b_pc", P);
    mem_ack = 1'b0;
    now("t5b_stat", 32'd1, 32'(stat));
    cyc("t5b_fetch2", F);

    // reset asserted mid-MEMORY takes effect without a clock edge
    do_reset();
    start = 1'b1; icode = 4'h5;
    cyc("t6_fetch", F);
    cyc("t6_decode", D);
    cyc("t6_exec", E);
    cyc("t6_mem", M);
    #1;
    rst_n = 1'b0;
    #1;
    now("t6_mem_req", 32'd0, 32'(mem_req));
    now("t6_en", Z, en_vec());
    now("t6_stat", 32'd1, 32'(stat));
    now("t6_busy", 32'd0, 32'(busy));
    now("t6_ret", 32'd0, instr_retired);
    now("t6_cyc", 32'd0, cycle_count);
    step();
    rst_n = 1'b1; start = 1'b0;
    cyc("t6_idle", Z);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
